// File: rtl/bp_cce_cfg_slave.sv
// Config-link target: decodes io_cmd writes/reads to the tile config registers and the CCE ucode RAM.
// Latency: accept->resp valid 2 cycles (register) / 3 cycles (ucode read, immediate yumi); one command in flight.
// Backpressure: io_cmd is yumi'd only in IDLE; RESP holds io_resp_v_o until io_resp_ready_i; ucode request holds until yumi.
//
// Ports:
//   clk_i, reset_i (async, active-high)           clock / reset
//   cce_id_i                                        this tile's CCE id, used for address hit
//   io_cmd_i / io_cmd_v_i / io_cmd_yumi_o           command stream in (valid/yumi)
//   io_resp_o / io_resp_v_o / io_resp_ready_i       one response per command (valid/ready)
//   reset_o, freeze_o, npc_o, *_mode_o              config register outputs
//   cce_ucode_*                                     CCE instruction RAM port (valid/yumi, read data one cycle later)
//
// Message layout (MSB..LSB): msg_type[1:0], addr, size[2:0], payload, data.
// Config address layout (MSB..LSB): nonlocal, cce, dev[3:0], cfg addr.
module bp_cce_cfg_slave #(
   parameter int paddr_width_p         = 40,
   parameter int dword_width_p         = 64,
   parameter int lce_id_width_p        = 4,
   parameter int cce_id_width_p        = 6,
   parameter int vaddr_width_p         = 39,
   parameter int cfg_addr_width_p      = 16,
   parameter int inst_ram_addr_width_p = 8,
   parameter int inst_width_p          = 48,
   parameter logic [3:0] cfg_dev_gp    = 4'h1,
   localparam int cce_io_msg_width_lp  = 2 + paddr_width_p + 3 + lce_id_width_p + dword_width_p
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [cce_id_width_p-1:0]        cce_id_i,

   input  logic [cce_io_msg_width_lp-1:0]   io_cmd_i,
   input  logic                             io_cmd_v_i,
   output logic                             io_cmd_yumi_o,

   output logic [cce_io_msg_width_lp-1:0]   io_resp_o,
   output logic                             io_resp_v_o,
   input  logic                             io_resp_ready_i,

   output logic                             reset_o,
   output logic                             freeze_o,
   output logic [vaddr_width_p-1:0]         npc_o,
   output logic                             icache_mode_o,
   output logic                             dcache_mode_o,
   output logic                             cce_mode_o,

   output logic                             cce_ucode_v_o,
   output logic                             cce_ucode_w_o,
   output logic [inst_ram_addr_width_p-1:0] cce_ucode_addr_o,
   output logic [inst_width_p-1:0]          cce_ucode_data_o,
   input  logic                             cce_ucode_yumi_i,
   input  logic [inst_width_p-1:0]          cce_ucode_data_i
);

   localparam int dev_width_lp      = 4;
   localparam int nonlocal_width_lp = paddr_width_p - cfg_addr_width_p - dev_width_lp - cce_id_width_p;

   localparam logic [1:0] e_cce_io_rd = 2'b00;
   localparam logic [1:0] e_cce_io_wr = 2'b01;

   localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_reset_gp        = 'h0001;
   localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_freeze_gp       = 'h0002;
   localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_npc_gp          = 'h0004;
   localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_icache_mode_gp  = 'h0006;
   localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_dcache_mode_gp  = 'h0007;
   localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_cce_mode_gp     = 'h0008;
   localparam logic [cfg_addr_width_p-1:0] bp_cfg_mem_base_cce_ucode_gp = 'h8000;

   typedef struct packed {
      logic [1:0]                msg_type;
      logic [paddr_width_p-1:0]  addr;
      logic [2:0]                size;
      logic [lce_id_width_p-1:0] payload;
      logic [dword_width_p-1:0]  data;
   } cce_io_msg_s;

   typedef struct packed {
      logic [nonlocal_width_lp-1:0] nonlocal;
      logic [cce_id_width_p-1:0]    cce;
      logic [dev_width_lp-1:0]      dev;
      logic [cfg_addr_width_p-1:0]  addr;
   } cfg_addr_s;

   typedef enum logic [1:0] {
      e_idle,
      e_exec,
      e_ucode_rd,
      e_resp
   } state_e;

   state_e                   state_r;
   cce_io_msg_s              cmd_r;
   logic                     reg_hit_r;   // local hit on the register space (not ucode window)
   logic [dword_width_p-1:0] resp_data_r;

   cce_io_msg_s cmd_in;
   cfg_addr_s   addr_in;
   cfg_addr_s   addr_r;
   logic        hit_in;
   logic        ucode_in;

   assign cmd_in  = io_cmd_i;
   assign addr_in = cmd_in.addr;
   assign addr_r  = cmd_r.addr;

   // Decode is done on the incoming command so the ucode request can be
   // raised from a flop in the very first EXEC cycle.
   assign hit_in   = (addr_in.nonlocal == '0) && (addr_in.cce == cce_id_i) && (addr_in.dev == cfg_dev_gp);
   assign ucode_in = hit_in && (addr_in.addr >= bp_cfg_mem_base_cce_ucode_gp);

   // reset_i gates the accept so nothing is consumed while reset is held.
   assign io_cmd_yumi_o = io_cmd_v_i && (state_r == e_idle) && !reset_i;

   assign io_resp_o = {cmd_r.msg_type, cmd_r.addr, cmd_r.size, cmd_r.payload, resp_data_r};

   logic [dword_width_p-1:0] reg_rd_val;
   always_comb begin
      reg_rd_val = '0;
      if (reg_hit_r) begin
         case (addr_r.addr)
            bp_cfg_reg_reset_gp:       reg_rd_val[0] = reset_o;
            bp_cfg_reg_freeze_gp:      reg_rd_val[0] = freeze_o;
            bp_cfg_reg_npc_gp:         reg_rd_val[vaddr_width_p-1:0] = npc_o;
            bp_cfg_reg_icache_mode_gp: reg_rd_val[0] = icache_mode_o;
            bp_cfg_reg_dcache_mode_gp: reg_rd_val[0] = dcache_mode_o;
            bp_cfg_reg_cce_mode_gp:    reg_rd_val[0] = cce_mode_o;
            default:                   reg_rd_val = '0;
         endcase
      end
   end

   logic [dword_width_p-1:0] ucode_rd_ext;
   always_comb begin
      ucode_rd_ext = '0;
      ucode_rd_ext[inst_width_p-1:0] = cce_ucode_data_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r          <= e_idle;
         cmd_r            <= '0;
         reg_hit_r        <= 1'b0;
         resp_data_r      <= '0;
         io_resp_v_o      <= 1'b0;
         reset_o          <= 1'b1;
         freeze_o         <= 1'b1;
         npc_o            <= '0;
         icache_mode_o    <= 1'b0;
         dcache_mode_o    <= 1'b0;
         cce_mode_o       <= 1'b0;
         cce_ucode_v_o    <= 1'b0;
         cce_ucode_w_o    <= 1'b0;
         cce_ucode_addr_o <= '0;
         cce_ucode_data_o <= '0;
      end else begin
         case (state_r)
            e_idle: begin
               if (io_cmd_yumi_o) begin
                  cmd_r     <= cmd_in;
                  reg_hit_r <= hit_in && !ucode_in;
                  if (ucode_in) begin
                     cce_ucode_v_o    <= 1'b1;
                     cce_ucode_w_o    <= (cmd_in.msg_type == e_cce_io_wr);
                     cce_ucode_addr_o <= addr_in.addr[inst_ram_addr_width_p-1:0];
                     cce_ucode_data_o <= cmd_in.data[inst_width_p-1:0];
                  end
                  state_r <= e_exec;
               end
            end

            e_exec: begin
               if (cce_ucode_v_o) begin
                  // Ucode target: request stays stable until the RAM takes it.
                  if (cce_ucode_yumi_i) begin
                     cce_ucode_v_o <= 1'b0;
                     if (cce_ucode_w_o) begin
                        resp_data_r <= '0;
                        io_resp_v_o <= 1'b1;
                        state_r     <= e_resp;
                     end else begin
                        state_r     <= e_ucode_rd;
                     end
                  end
               end else begin
                  if (reg_hit_r && (cmd_r.msg_type == e_cce_io_wr)) begin
                     case (addr_r.addr)
                        bp_cfg_reg_reset_gp:       reset_o       <= cmd_r.data[0];
                        bp_cfg_reg_freeze_gp:      freeze_o      <= cmd_r.data[0];
                        bp_cfg_reg_npc_gp:         npc_o         <= cmd_r.data[vaddr_width_p-1:0];
                        bp_cfg_reg_icache_mode_gp: icache_mode_o <= cmd_r.data[0];
                        bp_cfg_reg_dcache_mode_gp: dcache_mode_o <= cmd_r.data[0];
                        bp_cfg_reg_cce_mode_gp:    cce_mode_o    <= cmd_r.data[0];
                        default: ;
                     endcase
                  end
                  resp_data_r <= (cmd_r.msg_type == e_cce_io_rd) ? reg_rd_val : '0;
                  io_resp_v_o <= 1'b1;
                  state_r     <= e_resp;
               end
            end

            e_ucode_rd: begin
               resp_data_r <= (cmd_r.msg_type == e_cce_io_rd) ? ucode_rd_ext : '0;
               io_resp_v_o <= 1'b1;
               state_r     <= e_resp;
            end

            e_resp: begin
               if (io_resp_ready_i) begin
                  io_resp_v_o <= 1'b0;
                  state_r     <= e_idle;
               end
            end

            default: state_r <= e_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_cce_cfg_slave.sv
// Directed bench for bp_cce_cfg_slave with a small behavioural ucode RAM.
// Inputs are driven 1 time unit after the rising edge; outputs sampled there too.
// All expected values are hand-computed constants or built by mk_cmd.
module tb_bp_cce_cfg_slave;

   localparam int MSG_W = 2 + 40 + 3 + 4 + 64;
   localparam logic [1:0] RD = 2'b00;
   localparam logic [1:0] WR = 2'b01;
   localparam logic [5:0] MY_CCE = 6'd3;

   logic             clk = 1'b0;
   logic             reset_i;
   logic [5:0]       cce_id_i;
   logic [MSG_W-1:0] io_cmd_i;
   logic             io_cmd_v_i;
   logic             io_cmd_yumi_o;
   logic [MSG_W-1:0] io_resp_o;
   logic             io_resp_v_o;
   logic             io_resp_ready_i;
   logic             reset_o;
   logic             freeze_o;
   logic [38:0]      npc_o;
   logic             icache_mode_o;
   logic             dcache_mode_o;
   logic             cce_mode_o;
   logic             cce_ucode_v_o;
   logic             cce_ucode_w_o;
   logic [7:0]       cce_ucode_addr_o;
   logic [47:0]      cce_ucode_data_o;
   logic             cce_ucode_yumi_i;
   logic [47:0]      cce_ucode_data_i;

   always #5 clk = ~clk;

   bp_cce_cfg_slave dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .cce_id_i         (cce_id_i),
      .io_cmd_i         (io_cmd_i),
      .io_cmd_v_i       (io_cmd_v_i),
      .io_cmd_yumi_o    (io_cmd_yumi_o),
      .io_resp_o        (io_resp_o),
      .io_resp_v_o      (io_resp_v_o),
      .io_resp_ready_i  (io_resp_ready_i),
      .reset_o          (reset_o),
      .freeze_o         (freeze_o),
      .npc_o            (npc_o),
      .icache_mode_o    (icache_mode_o),
      .dcache_mode_o    (dcache_mode_o),
      .cce_mode_o       (cce_mode_o),
      .cce_ucode_v_o    (cce_ucode_v_o),
      .cce_ucode_w_o    (cce_ucode_w_o),
      .cce_ucode_addr_o (cce_ucode_addr_o),
      .cce_ucode_data_o (cce_ucode_data_o),
      .cce_ucode_yumi_i (cce_ucode_yumi_i),
      .cce_ucode_data_i (cce_ucode_data_i)
   );

   // Behavioural ucode RAM: accepts whenever not stalled, read data one cycle later.
   logic        ram_stall;
   logic [47:0] ram [256];
   assign cce_ucode_yumi_i = cce_ucode_v_o && !ram_stall;
   always @(posedge clk) begin
      if (cce_ucode_v_o && cce_ucode_yumi_i) begin
         if (cce_ucode_w_o) ram[cce_ucode_addr_o] <= cce_ucode_data_o;
         else               cce_ucode_data_i      <= ram[cce_ucode_addr_o];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [MSG_W-1:0] mk_cmd(input logic [1:0] typ, input logic [5:0] cce,
                                                input logic [3:0] dev, input logic [15:0] cfg,
                                                input logic [63:0] data);
      logic [39:0] a;
      a = {14'd0, cce, dev, cfg};
      return {typ, a, 3'd3, 4'h2, data};
   endfunction

   // Present a command and return one cycle after the accepting edge (DUT in EXEC).
   task automatic issue(input logic [MSG_W-1:0] m);
      int n;
      n = 0;
      io_cmd_i   = m;
      io_cmd_v_i = 1'b1;
      #1;
      while (!io_cmd_yumi_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("cmd_accept", io_cmd_yumi_o, 1'b1);
      @(posedge clk); #1;
      io_cmd_v_i = 1'b0;
   endtask

   // Wait (bounded) for a response, sample it, complete the handshake (ready assumed high).
   task automatic get_resp(output logic [MSG_W-1:0] r);
      int n;
      n = 0;
      while (!io_resp_v_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("resp_arrives", io_resp_v_o, 1'b1);
      r = io_resp_o;
      @(posedge clk); #1;
   endtask

   logic [MSG_W-1:0] r;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = '0;
      cce_ucode_data_i = '0;
      reset_i = 1'b1;
      cce_id_i = MY_CCE;
      io_cmd_i = '0;
      io_cmd_v_i = 1'b0;
      io_resp_ready_i = 1'b1;
      ram_stall = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_reset_o", reset_o, 1'b1);
      check("rst_freeze_o", freeze_o, 1'b1);
      check("rst_npc", npc_o, 39'd0);
      check("rst_modes", {icache_mode_o, dcache_mode_o, cce_mode_o}, 3'b000);
      check("rst_resp_v", io_resp_v_o, 1'b0);
      check("rst_ucode_v", cce_ucode_v_o, 1'b0);

      // Freeze release: output moves one cycle after accept, response one more
      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h0002, 64'd0));
      check("frz_exec_still1", freeze_o, 1'b1);
      check("frz_exec_no_resp", io_resp_v_o, 1'b0);
      @(posedge clk); #1;
      check("frz_fell", freeze_o, 1'b0);
      check("frz_resp_v", io_resp_v_o, 1'b1);
      check("frz_resp", io_resp_o, mk_cmd(WR, MY_CCE, 4'h1, 16'h0002, 64'd0));
      @(posedge clk); #1;
      check("frz_resp_done", io_resp_v_o, 1'b0);

      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h0001, 64'd0));
      check("rstreg_exec_still1", reset_o, 1'b1);
      @(posedge clk); #1;
      check("rstreg_fell", reset_o, 1'b0);
      check("rstreg_resp_v", io_resp_v_o, 1'b1);
      check("rstreg_resp", io_resp_o, mk_cmd(WR, MY_CCE, 4'h1, 16'h0001, 64'd0));
      @(posedge clk); #1;

      // NPC write (upper data bits beyond vaddr width ignored) and read back
      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h0004, 64'hFFFF_FF80_8000_0000));
      get_resp(r);
      check("npc_wr_resp", r, mk_cmd(WR, MY_CCE, 4'h1, 16'h0004, 64'hFFFF_FF80_8000_0000) & ~{{(MSG_W-64){1'b0}}, 64'hFFFF_FFFF_FFFF_FFFF});
      check("npc_o", npc_o, 39'h00_8000_0000);
      issue(mk_cmd(RD, MY_CCE, 4'h1, 16'h0004, 64'h1234));
      get_resp(r);
      check("npc_rd_resp", r, mk_cmd(RD, MY_CCE, 4'h1, 16'h0004, 64'h8000_0000));

      // Mode registers
      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h0006, 64'd1)); get_resp(r);
      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h0008, 64'd1)); get_resp(r);
      check("modes_ic_cce", {icache_mode_o, dcache_mode_o, cce_mode_o}, 3'b101);
      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h0007, 64'hFE)); get_resp(r);
      check("dcache_lowbit0", dcache_mode_o, 1'b0);
      issue(mk_cmd(RD, MY_CCE, 4'h1, 16'h0006, 64'd0)); get_resp(r);
      check("icache_rd", r[63:0], 64'd1);

      // Ucode write with RAM stalled three cycles
      ram_stall = 1'b1;
      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h8005, 64'hABC));
      for (int i = 0; i < 3; i++) begin
         check("uc_stall_v", cce_ucode_v_o, 1'b1);
         check("uc_stall_req", {cce_ucode_w_o, cce_ucode_addr_o, cce_ucode_data_o}, {1'b1, 8'd5, 48'hABC});
         check("uc_stall_no_resp", io_resp_v_o, 1'b0);
         @(posedge clk); #1;
      end
      ram_stall = 1'b0;
      get_resp(r);
      check("uc_wr_resp", r, mk_cmd(WR, MY_CCE, 4'h1, 16'h8005, 64'd0));
      check("uc_ram_written", ram[5], 48'hABC);

      // Ucode read with immediate yumi: response three cycles after accept
      issue(mk_cmd(RD, MY_CCE, 4'h1, 16'h8005, 64'd0));
      check("ucrd_req", {cce_ucode_v_o, cce_ucode_w_o, cce_ucode_addr_o}, {1'b1, 1'b0, 8'd5});
      @(posedge clk); #1;
      check("ucrd_n2_no_resp", io_resp_v_o, 1'b0);
      @(posedge clk); #1;
      check("ucrd_n3_resp_v", io_resp_v_o, 1'b1);
      check("ucrd_resp", io_resp_o, mk_cmd(RD, MY_CCE, 4'h1, 16'h8005, 64'hABC));
      @(posedge clk); #1;

      // Miss on CCE id: read returns 0 even though npc is nonzero
      issue(mk_cmd(RD, 6'd5, 4'h1, 16'h0004, 64'd0));
      get_resp(r);
      check("miss_rd_data", r[63:0], 64'd0);

      // Unmapped write with response held off for 4 cycles
      io_resp_ready_i = 1'b0;
      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h0100, 64'hFFFF));
      @(posedge clk); #1;
      io_cmd_i   = mk_cmd(RD, MY_CCE, 4'h1, 16'h0002, 64'd0);
      io_cmd_v_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("hold_resp_v", io_resp_v_o, 1'b1);
         check("hold_no_yumi", io_cmd_yumi_o, 1'b0);
         @(posedge clk); #1;
      end
      check("unmapped_resp", io_resp_o, mk_cmd(WR, MY_CCE, 4'h1, 16'h0100, 64'd0));
      io_resp_ready_i = 1'b1;
      @(posedge clk); #1;
      check("unmapped_no_change", {reset_o, freeze_o, npc_o, icache_mode_o, dcache_mode_o, cce_mode_o},
            {1'b0, 1'b0, 39'h00_8000_0000, 1'b1, 1'b0, 1'b1});
      issue(mk_cmd(RD, MY_CCE, 4'h1, 16'h0002, 64'd0));
      get_resp(r);
      check("freeze_rd", r[63:0], 64'd0);

      // Reset asserted during a stalled ucode write
      ram_stall = 1'b1;
      issue(mk_cmd(WR, MY_CCE, 4'h1, 16'h8009, 64'h555));
      check("pre_rst_uc_v", cce_ucode_v_o, 1'b1);
      reset_i = 1'b1;
      #1;
      check("async_uc_v", cce_ucode_v_o, 1'b0);
      check("async_resp_v", io_resp_v_o, 1'b0);
      check("async_regs", {reset_o, freeze_o, npc_o, icache_mode_o, dcache_mode_o, cce_mode_o},
            {1'b1, 1'b1, 39'd0, 3'b000});
      @(posedge clk); #1;
      reset_i   = 1'b0;
      ram_stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("post_rst_quiet", {io_resp_v_o, cce_ucode_v_o}, 2'b00);
      end
      check("post_rst_ram_untouched", ram[9], 48'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bp_cce_cfg_slave.md
Name: bp_cce_cfg_slave

Overview:
- Config-channel target that consumes the io_cmd stream produced by the config loader on the tile's config link, and returns one io_resp per command.
- Decodes local config addresses and holds the tile's config registers: reset, freeze, cache modes, CCE mode and next-PC.
- Forwards CCE microcode reads and writes to the CCE instruction RAM over a valid/yumi port.
- Handles one command at a time: IDLE -> EXEC -> (UCODE_RD) -> RESP.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; supplies paddr_width_p, dword_width_p, lce_id_width_p, cce_id_width_p, vaddr_width_p, cfg_addr_width_p.
- inst_ram_addr_width_p, "inv", CCE ucode RAM address width.
- inst_width_p, "inv", CCE ucode instruction width (<= dword_width_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- cce_id_i  in  cce_id_width_p  this tile's CCE id.
- io_cmd_i  in  cce_io_msg_width_lp  bp_cce_io_msg_s command; fields used: msg_type, addr, size, payload, data.
- io_cmd_v_i  in  1  command valid.
- io_cmd_yumi_o  out  1  command consumed.
- io_resp_o  out  cce_io_msg_width_lp  response message.
- io_resp_v_o  out  1  response valid.
- io_resp_ready_i  in  1  response sink ready.
- reset_o  out  1  core soft reset.
- freeze_o  out  1  core freeze.
- npc_o  out  vaddr_width_p  boot PC.
- icache_mode_o  out  1  e_lce_mode_* for the I$.
- dcache_mode_o  out  1  e_lce_mode_* for the D$.
- cce_mode_o  out  1  e_cce_mode_*.
- cce_ucode_v_o  out  1  ucode RAM request valid.
- cce_ucode_w_o  out  1  1 = write, 0 = read.
- cce_ucode_addr_o  out  inst_ram_addr_width_p  ucode RAM address.
- cce_ucode_data_o  out  inst_width_p  ucode write data.
- cce_ucode_yumi_i  in  1  ucode request accepted.
- cce_ucode_data_i  in  inst_width_p  ucode read data, valid the cycle after the accepted read.

Behaviour:
- Address decode:
  - Hit requires addr.nonlocal==0, addr.cce==cce_id_i and addr.dev==cfg_dev_gp; cfg address = addr.addr.
  - Register map: bp_cfg_reg_reset_gp=0x0001, bp_cfg_reg_freeze_gp=0x0002, bp_cfg_reg_npc_gp=0x0004, bp_cfg_reg_icache_mode_gp=0x0006, bp_cfg_reg_dcache_mode_gp=0x0007, bp_cfg_reg_cce_mode_gp=0x0008.
  - Ucode window: cfg addr >= bp_cfg_mem_base_cce_ucode_gp (0x8000); RAM address = low inst_ram_addr_width_p bits.
- Reset (async, any state): state=IDLE; reset_o=1, freeze_o=1, npc_o=0, all modes=0 (uncached), io_resp_v_o=0, cce_ucode_v_o=0, io_cmd_yumi_o=0.
  - An in-flight command is dropped: no response, no partial ucode request.
- IDLE:
  - io_cmd_yumi_o = io_cmd_v_i (combinational).
  - On yumi, latch the whole command and go to EXEC.
- EXEC, register target:
  - Write: updates the target register at the end of EXEC, using the low bits of data (npc uses low vaddr_width_p bits).
  - Read: captures the zero-extended register value.
  - Next state RESP.
- EXEC, ucode target:
  - Hold cce_ucode_v_o=1 with w/addr/data stable until cce_ucode_yumi_i.
  - Write -> RESP; read -> UCODE_RD.
  - No timeout.
- UCODE_RD: capture cce_ucode_data_i, zero-extended to dword, then RESP.
- Miss or unmapped address: write has no effect, read returns 0; a response is still sent.
- RESP:
  - io_resp_v_o=1 until io_resp_ready_i.
  - Response fields: msg_type, addr, size and payload echoed from the command; data = read value for e_cce_io_rd, 0 for e_cce_io_wr.
  - On the handshake, return to IDLE.
  - io_cmd_yumi_o=0 in every state except IDLE, so there are no back-to-back accepts.
- Latency, with ready held high:
  - Register write: accept at cycle N, register output changes at N+1 edge, resp valid N+2.
  - Ucode read with immediate yumi: resp valid N+3.
  - Throughput: 1 command per 3 cycles (register) or 4 cycles (ucode read).
- Register values persist until rewritten; no register is cleared by access.

Test Plan:
- After reset release, no stimulus -> reset_o=1, freeze_o=1, npc_o=0, modes=0, io_resp_v_o=0, cce_ucode_v_o=0.
- Write 0x0002 data=0, then 0x0001 data=0, ready=1 -> freeze_o falls 1 cycle after its accept, resp valid 2 cycles after accept with data=0; same sequence for reset_o.
- Write npc 0x0004 data=0x80000000, then read it back -> npc_o=0x80000000; read resp data=0x80000000, msg_type=e_cce_io_rd, addr echoed.
- Ucode write at cfg 0x8005 data=0xABC, yumi delayed 3 cycles, then read 0x8005 with RAM returning 0xABC -> addr_o=5 and request stable during the stall; read resp data=0xABC.
- Read addr.cce != cce_id_i, then write an unmapped address 0x0100 -> resp data=0, no register change; io_resp_ready_i low 4 cycles holds resp valid and blocks io_cmd_yumi_o.
- Assert reset_i in EXEC during a stalled ucode write -> cce_ucode_v_o and io_resp_v_o drop immediately, registers return to reset values, no response emitted.
